// File: rtl/aes_cipher_collector_pkg.sv
// rtl/aes_cipher_collector_pkg.sv - shared widths, block type and byte-insertion helper
package aes_cipher_collector_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTES   = 16;
  localparam int AES_IDX_W   = 4;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  // MSB-first shifts left so byte 0 ends at the top; LSB-first shifts right so byte 0 ends at [7:0]
  function automatic aes_block_t shift_in(aes_block_t cur, logic [7:0] b, logic msb_first);
    if (msb_first) return {cur[AES_BLOCK_W-9:0], b};
    else           return {b, cur[AES_BLOCK_W-1:8]};
  endfunction
endpackage

// File: rtl/aes_cipher_collector_fifo.sv
// rtl/aes_cipher_collector_fifo.sv - circular buffer of completed 128-bit blocks
module aes_block_fifo
  import aes_cipher_collector_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       push,
  input  aes_block_t push_data,
  input  logic       pop,
  output aes_block_t head,
  output logic       full,
  output logic       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  aes_block_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occupancy;
  logic             do_pop;
  logic             do_push;

  assign full    = (occupancy == OCC_W'(DEPTH));
  assign empty   = (occupancy == '0);
  assign do_pop  = pop && !empty;
  // a pop in the same edge frees the slot the write pointer lands on
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      occupancy <= occupancy + OCC_W'(1);
      else if (do_pop && !do_push) occupancy <= occupancy - OCC_W'(1);
    end
  end
endmodule

// File: rtl/aes_cipher_collector.sv
// rtl/aes_cipher_collector.sv - reassembles engine bytes into 128-bit blocks for the host
module aes_cipher_collector
  import aes_cipher_collector_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [7:0]             din,
  input  logic                   din_ok,
  output logic [AES_BLOCK_W-1:0] block_out,
  output logic                   block_valid,
  input  logic                   block_ready,
  output logic                   overflow,
  input  logic                   clr_overflow,
  output logic [CNT_W-1:0]       block_count,
  output logic                   busy
);
  logic [AES_IDX_W-1:0] idx;
  aes_block_t           shreg;
  aes_block_t           next_word;
  logic                 complete;
  logic                 pop;
  logic                 push_ok;
  logic                 full;
  logic                 empty;

  assign next_word   = shift_in(shreg, din, MSB_FIRST != 0);
  assign complete    = din_ok && (idx == AES_IDX_W'(AES_BYTES - 1));
  assign pop         = block_ready && !empty;
  assign push_ok     = complete && (!full || pop);
  assign block_valid = !empty;
  assign busy        = (idx != '0);

  aes_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_      (rst_),
    .push      (complete),
    .push_data (next_word),
    .pop       (pop),
    .head      (block_out),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_) begin
      idx         <= '0;
      shreg       <= '0;
      overflow    <= 1'b0;
      block_count <= '0;
    end else begin
      if (din_ok) begin
        shreg <= next_word;
        idx   <= idx + AES_IDX_W'(1);
      end
      // a dropped block outranks a clear arriving on the same edge
      if (complete && !push_ok) overflow <= 1'b1;
      else if (clr_overflow)    overflow <= 1'b0;
      if (push_ok) block_count <= block_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_aes_cipher_collector.sv
// tb/tb_aes_cipher_collector.sv - scoreboard bench for two collector configurations
module tb_aes_cipher_collector;
  logic         clk = 1'b0;
  logic         rst_ = 1'b0;
  logic [7:0]   din = 8'h00;
  logic         din_ok = 1'b0;
  logic         block_ready = 1'b0;
  logic         clr_overflow = 1'b0;
  logic [127:0] bo [2];
  logic         bv [2];
  logic         ovf [2];
  logic         bsy [2];
  logic [3:0]   bc0;
  logic [15:0]  bc1;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 0;

  logic [7:0]   bq [2][$];
  logic [127:0] fq [2][$];
  logic [127:0] sb [2][$];
  int           cnt_m [2];
  bit           ovf_m [2];
  int           dep [2]   = '{2, 4};
  bit           msb [2]   = '{1'b1, 1'b0};
  int           cmask [2] = '{15, 65535};

  always #5 clk = ~clk;

  aes_cipher_collector #(.DEPTH(2), .MSB_FIRST(1), .CNT_W(4)) dut0 (
    .clk(clk), .rst_(rst_), .din(din), .din_ok(din_ok), .block_out(bo[0]),
    .block_valid(bv[0]), .block_ready(block_ready), .overflow(ovf[0]),
    .clr_overflow(clr_overflow), .block_count(bc0), .busy(bsy[0]));

  aes_cipher_collector #(.DEPTH(4), .MSB_FIRST(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst_(rst_), .din(din), .din_ok(din_ok), .block_out(bo[1]),
    .block_valid(bv[1]), .block_ready(block_ready), .overflow(ovf[1]),
    .clr_overflow(clr_overflow), .block_count(bc1), .busy(bsy[1]));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: byte list -> block, bounded queue for the FIFO
  task automatic model_step(input int k);
    logic [127:0] blk;
    bit           do_pop;
    bit           new_ovf;
    if (!rst_) begin
      bq[k].delete(); fq[k].delete(); sb[k].delete();
      cnt_m[k] = 0; ovf_m[k] = 0;
      return;
    end
    new_ovf = 0;
    do_pop  = (fq[k].size() > 0) && block_ready;
    if (do_pop) void'(fq[k].pop_front());
    if (din_ok) begin
      bq[k].push_back(din);
      if (bq[k].size() == 16) begin
        blk = '0;
        for (int i = 0; i < 16; i++) begin
          if (msb[k]) blk[127 - 8*i -: 8] = bq[k][i];
          else        blk[8*i +: 8]       = bq[k][i];
        end
        bq[k].delete();
        if (fq[k].size() < dep[k]) begin
          fq[k].push_back(blk);
          sb[k].push_back(blk);
          cnt_m[k] = (cnt_m[k] + 1) & cmask[k];
        end else new_ovf = 1;
      end
    end
    if (new_ovf) ovf_m[k] = 1;
    else if (clr_overflow) ovf_m[k] = 0;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("valid%0d", k), {127'b0, bv[k]}, {127'b0, fq[k].size() != 0});
        chk($sformatf("count%0d", k), (k == 0) ? {124'b0, bc0} : {112'b0, bc1}, 128'(cnt_m[k]));
        chk($sformatf("overflow%0d", k), {127'b0, ovf[k]}, {127'b0, ovf_m[k]});
        chk($sformatf("busy%0d", k), {127'b0, bsy[k]}, {127'b0, bq[k].size() != 0});
        if (bv[k]) begin
          if (sb[k].size() == 0) chk($sformatf("sb_empty%0d", k), 128'd1, 128'd0);
          else begin
            chk($sformatf("block%0d", k), bo[k], sb[k][0]);
            if (block_ready) void'(sb[k].pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    din = b; din_ok = 1'b1;
    tick();
    din_ok = 1'b0; din = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic send_block(input logic [7:0] base, input bit gapped);
    for (int i = 0; i < 16; i++)
      send_byte(base + 8'(i), gapped ? ((i == 7) ? 5 : 1) : 0);
  endtask

  task automatic do_reset();
    rst_ = 1'b0; tick(); rst_ = 1'b1;
  endtask

  task automatic pop_n(input int n);
    block_ready = 1'b1; repeat (n) tick(); block_ready = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst_ = 1'b1;
    mon_en = 1;
    @(negedge clk);
    chk("reset_block_out", bo[0], 128'h0);
    tick();

    send_block(8'h00, 0);
    @(negedge clk);
    chk("single_msb", bo[0], 128'h000102030405060708090A0B0C0D0E0F);
    chk("single_lsb", bo[1], 128'h0F0E0D0C0B0A09080706050403020100);
    chk("single_cnt", {124'b0, bc0}, 128'd1);
    tick(); pop_n(2);

    send_block(8'h00, 1);
    @(negedge clk);
    chk("gapped_msb", bo[0], 128'h000102030405060708090A0B0C0D0E0F);
    tick(); pop_n(2);

    do_reset();
    send_block(8'h10, 0); send_block(8'h20, 0); send_block(8'h30, 0);
    @(negedge clk);
    chk("ovf_flag", {127'b0, ovf[0]}, 128'd1);
    chk("ovf_cnt", {124'b0, bc0}, 128'd2);
    chk("ovf_head", bo[0], 128'h101112131415161718191A1B1C1D1E1F);
    chk("deep_cnt", {112'b0, bc1}, 128'd3);
    tick(); pop_n(2);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    @(negedge clk);
    chk("ovf_clr", {127'b0, ovf[0]}, 128'd0);
    tick();

    do_reset();
    send_block(8'h40, 0); send_block(8'h50, 0);
    for (int i = 0; i < 15; i++) send_byte(8'h60 + 8'(i), 0);
    block_ready = 1'b1;
    send_byte(8'h6F, 0);
    @(negedge clk);
    chk("pp_ovf", {127'b0, ovf[0]}, 128'd0);
    chk("pp_cnt", {124'b0, bc0}, 128'd3);
    tick(); repeat (5) tick(); block_ready = 1'b0;

    do_reset();
    for (int i = 0; i < 9; i++) send_byte(8'hEE, 0);
    do_reset();
    @(negedge clk);
    chk("midreset_busy", {127'b0, bsy[0]}, 128'd0);
    tick();
    send_block(8'hA0, 0);
    @(negedge clk);
    chk("midreset_blk", bo[0], 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    chk("midreset_cnt", {124'b0, bc0}, 128'd1);
    tick();

    do_reset();
    block_ready = 1'b1;
    for (int b = 0; b < 17; b++) send_block(8'($urandom), 0);
    tick(); tick();
    @(negedge clk);
    chk("wrap_cnt4", {124'b0, bc0}, 128'd1);
    chk("wrap_cnt16", {112'b0, bc1}, 128'd17);
    tick();

    for (int c = 0; c < 800; c++) begin
      din          = 8'($urandom);
      din_ok       = ($urandom_range(0, 3) != 0);
      block_ready  = ($urandom_range(0, 3) == 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      rst_         = ($urandom_range(0, 299) != 0);
      tick();
    end
    din_ok = 1'b0; clr_overflow = 1'b0; rst_ = 1'b1;
    pop_n(8);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
